usb_tx_encoder: RTL and testbench

Serial back end of the USB full-speed transmit path. It consumes the one-cycle bit-period strobe produced by the TX bit-timing counter and a byte stream from the TX packet controller. On each bit period it shifts bits LSB-first, inserts stuff bits, NRZI-encodes the result and drives D+/D-. It prefixes the packet with SYNC and terminates it with EOP.

---
 rtl/usb_tx_pkg.sv | 22 ++
 rtl/usb_nrzi_encoder.sv | 50 +++++
 rtl/usb_tx_encoder.sv | 186 ++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit encoder.
//   tx_enc_state_t : encoder FSM states
//   SYNC_BYTE      : SYNC pattern, sent LSB first (seven 0s then a 1)
//   LINE_*         : line states ordered {dplus, dminus}
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } tx_enc_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_nrzi_encoder.sv
// NRZI line driver for the USB transmit path.
// Holds the registered {D+, D-} line state and advances it once per bit strobe.
//   clk, n_rst  : clock, asynchronous active-low reset (line resets to J)
//   bit_strobe  : advance the line this cycle
//   bit_val     : bit to encode; 0 toggles J<->K, 1 holds the line
//   force_se0   : drive SE0 instead of encoding bit_val
//   force_j     : drive J instead of encoding bit_val
//   dplus_out, dminus_out : registered line drive
module usb_nrzi_encoder
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic bit_strobe,
    input  logic bit_val,
    input  logic force_se0,
    input  logic force_j,
    output logic dplus_out,
    output logic dminus_out
);

    logic [1:0] line_q;
    logic [1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (bit_strobe) begin
            if (force_se0) begin
                line_d = LINE_SE0;
            end else if (force_j) begin
                line_d = LINE_J;
            end else if (!bit_val) begin
                // Anything that is not K (J, or SE0 in an abnormal sequence) toggles to K.
                line_d = (line_q == LINE_K) ? LINE_J : LINE_K;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            line_q <= LINE_J;
        end else begin
            line_q <= line_d;
        end
    end

    assign dplus_out  = line_q[1];
    assign dminus_out = line_q[0];

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit serial back end.
// Sends SYNC, then payload bytes LSB first with bit stuffing, NRZI-encoded, then EOP.
//   clk, n_rst      : clock, asynchronous active-low reset (aborts any packet, line J)
//   bit_strobe      : one-cycle pulse per USB bit period
//   tx_start        : begin a packet (sampled only when idle)
//   tx_data, tx_data_valid, tx_last : payload byte stream
//   tx_data_ready   : pulse, tx_data consumed this cycle
//   tx_busy         : packet in progress
//   tx_done         : pulse at the end of the EOP J bit
//   tx_underrun     : pulse, a byte was needed but none was valid
//   dplus_out, dminus_out : registered line drive
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int unsigned STUFF_LIMIT = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       bit_strobe,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_last,
    output logic       tx_data_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_underrun,
    output logic       dplus_out,
    output logic       dminus_out
);

    localparam int unsigned ONES_W = $clog2(STUFF_LIMIT + 1);

    tx_enc_state_t state_q, state_d;
    tx_enc_state_t ret_q, ret_d;      // state to resume after a stuffed bit
    tx_enc_state_t nxt_state;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [ONES_W-1:0] ones_inc;
    logic              last_q, last_d;
    logic              eop_q, eop_d;  // second SE0 period / J period already driven

    logic enc_strobe;
    logic enc_bit;
    logic force_se0;
    logic force_j;

    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        nxt_state     = state_q;
        shift_d       = shift_q;
        bit_idx_d     = bit_idx_q;
        ones_d        = ones_q;
        last_d        = last_q;
        eop_d         = eop_q;
        ones_inc      = ones_q + 1'b1;
        enc_strobe    = 1'b0;
        enc_bit       = 1'b1;
        force_se0     = 1'b0;
        force_j       = 1'b0;
        tx_data_ready = 1'b0;
        tx_underrun   = 1'b0;
        tx_done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Start capture needs no strobe; the first SYNC bit goes on the next one.
                if (tx_start) begin
                    state_d   = SYNC;
                    shift_d   = SYNC_BYTE;
                    bit_idx_d = '0;
                    ones_d    = '0;
                    last_d    = 1'b0;
                end
            end

            SYNC, DATA: begin
                if (bit_strobe) begin
                    enc_strobe = 1'b1;
                    enc_bit    = shift_q[0];
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    ones_d     = shift_q[0] ? ones_inc : '0;
                    eop_d      = 1'b0;
                    nxt_state  = state_q;
                    if (bit_idx_q == 3'd7) begin
                        if (state_q == DATA && last_q) begin
                            nxt_state = EOP_SE0;
                        end else if (tx_data_valid) begin
                            shift_d       = tx_data;
                            last_d        = tx_last;
                            tx_data_ready = 1'b1;
                            nxt_state     = DATA;
                        end else begin
                            tx_underrun = 1'b1;
                            nxt_state   = EOP_SE0;
                        end
                    end
                    // A pending stuff bit always goes out before whatever comes next.
                    if (shift_q[0] && ones_inc == ONES_W'(STUFF_LIMIT)) begin
                        state_d = STUFF;
                        ret_d   = nxt_state;
                    end else begin
                        state_d = nxt_state;
                    end
                end
            end

            STUFF: begin
                if (bit_strobe) begin
                    enc_strobe = 1'b1;
                    enc_bit    = 1'b0;
                    ones_d     = '0;
                    state_d    = ret_q;
                end
            end

            EOP_SE0: begin
                if (bit_strobe) begin
                    enc_strobe = 1'b1;
                    force_se0  = 1'b1;
                    eop_d      = ~eop_q;
                    if (eop_q) begin
                        state_d = EOP_J;
                    end
                end
            end

            EOP_J: begin
                if (bit_strobe) begin
                    if (!eop_q) begin
                        enc_strobe = 1'b1;
                        force_j    = 1'b1;
                        eop_d      = 1'b1;
                    end else begin
                        // J period has elapsed; line already holds J.
                        tx_done = 1'b1;
                        ones_d  = '0;
                        eop_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            ret_q     <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            ones_q    <= '0;
            last_q    <= 1'b0;
            eop_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            ones_q    <= ones_d;
            last_q    <= last_d;
            eop_q     <= eop_d;
        end
    end

    assign tx_busy = (state_q != IDLE);

    usb_nrzi_encoder u_nrzi (
        .clk        (clk),
        .n_rst      (n_rst),
        .bit_strobe (enc_strobe),
        .bit_val    (enc_bit),
        .force_se0  (force_se0),
        .force_j    (force_j),
        .dplus_out  (dplus_out),
        .dminus_out (dminus_out)
    );

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder.
// Stimulus pushes one expected entry per bit strobe of a packet (line state after the
// strobe plus the {ready, underrun, done} pulses during it); the monitor pops and compares.
module tb_usb_tx_encoder;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       bit_strobe = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_data_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_underrun;
    logic       dplus_out;
    logic       dminus_out;

    usb_tx_encoder #(
        .STUFF_LIMIT (6)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .bit_strobe    (bit_strobe),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_last       (tx_last),
        .tx_data_ready (tx_data_ready),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_underrun   (tx_underrun),
        .dplus_out     (dplus_out),
        .dminus_out    (dminus_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] line;
        logic [2:0] pulses;  // {ready, underrun, done}
    } exp_t;

    exp_t       exp_q[$];
    exp_t       pend;
    exp_t       e;
    bit         pend_valid = 1'b0;
    bit         armed = 1'b0;
    bit         free_run = 1'b0;
    logic [7:0] byte_q[$];
    logic       lastf_q[$];
    int         pop_cnt = 0;
    int         pops_done = 0;
    int         div = 0;
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Input driver: strobe every 4 clocks, byte stream presented from byte_q.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (pops_done < pop_cnt) begin
                if (byte_q.size() > 0) begin
                    byte_q.delete(0);
                    lastf_q.delete(0);
                end
                pops_done++;
            end
            bit_strobe = (div == 0);
            div = (div == 3) ? 0 : div + 1;
            tx_data_valid = (byte_q.size() > 0);
            tx_data = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
            tx_last = (lastf_q.size() > 0) ? lastf_q[0] : 1'b0;
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (pend_valid) begin
                check("line", {6'b0, dplus_out, dminus_out}, {6'b0, pend.line});
                pend_valid = 1'b0;
            end
            if (bit_strobe && armed && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pulses", {5'b0, tx_data_ready, tx_underrun, tx_done}, {5'b0, e.pulses});
                check("busy", {7'b0, tx_busy}, 8'd1);
                pend = e;
                pend_valid = 1'b1;
                if (exp_q.size() == 0) armed = 1'b0;
            end else if (!free_run) begin
                check("no_pulse", {5'b0, tx_data_ready, tx_underrun, tx_done}, 8'd0);
            end
            if (tx_data_ready) pop_cnt++;
        end
    end

    // J/K/S per strobe; a final entry for the strobe ending the EOP J carries tx_done.
    task automatic push_str(input string s, input int r0, input int r1, input int u0);
        int   idx;
        exp_t x;
        idx = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] != " ") begin
                if (s[i] == "J") x.line = 2'b10;
                else if (s[i] == "K") x.line = 2'b01;
                else x.line = 2'b00;
                x.pulses = {(idx == r0) || (idx == r1), idx == u0, 1'b0};
                exp_q.push_back(x);
                idx++;
            end
        end
        x.line = 2'b10;
        x.pulses = 3'b001;
        exp_q.push_back(x);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic l);
        byte_q.push_back(b);
        lastf_q.push_back(l);
    endtask

    // align=1 puts tx_start in a strobe cycle; that strobe must not emit a bit.
    task automatic launch(input bit align);
        @(posedge clk);
        #2;
        while (bit_strobe != align) begin
            @(posedge clk);
            #2;
        end
        tx_start = 1'b1;
        @(posedge clk);
        #2;
        tx_start = 1'b0;
        armed = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || pend_valid) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d entries left expected 0", name, exp_q.size());
            exp_q.delete();
            pend_valid = 1'b0;
            armed = 1'b0;
        end
        @(posedge clk);
        #2;
        check({name, "_busy_end"}, {7'b0, tx_busy}, 8'd0);
        check({name, "_line_end"}, {6'b0, dplus_out, dminus_out}, 8'h02);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_line", {6'b0, dplus_out, dminus_out}, 8'h02);
        check("rst_busy", {7'b0, tx_busy}, 8'd0);
        check("rst_pulses", {5'b0, tx_data_ready, tx_underrun, tx_done}, 8'd0);
        @(posedge clk);
        #2;
        n_rst = 1'b1;
        repeat (8) @(posedge clk);

        // Single 0x00 byte.
        push_byte(8'h00, 1'b1);
        push_str("KJKJKJKK JKJKJKJK SSJ", 7, -1, -1);
        launch(1'b0);
        wait_idle("b00");

        // Single 0xFF byte with a stuff bit; tx_start coincides with a strobe.
        push_byte(8'hFF, 1'b1);
        push_str("KJKJKJKK KKKKKJJJJ SSJ", 7, -1, -1);
        launch(1'b1);
        wait_idle("bff");

        // Two bytes; valid is held while idle first, and tx_start mid-packet is ignored.
        push_byte(8'hA5, 1'b0);
        push_byte(8'h3C, 1'b1);
        repeat (12) @(posedge clk);
        push_str("KJKJKJKK KJJKJJKK JKKKKKJK SSJ", 7, 15, -1);
        launch(1'b0);
        repeat (50) @(posedge clk);
        #2;
        tx_start = 1'b1;
        @(posedge clk);
        #2;
        tx_start = 1'b0;
        wait_idle("two");

        // Underrun at the end of SYNC.
        push_str("KJKJKJKK SSJ", -1, -1, 7);
        launch(1'b0);
        wait_idle("und");

        // Reset mid-DATA.
        free_run = 1'b1;
        push_byte(8'h55, 1'b0);
        push_byte(8'h55, 1'b1);
        @(posedge clk);
        #2;
        tx_start = 1'b1;
        @(posedge clk);
        #2;
        tx_start = 1'b0;
        repeat (48) @(posedge clk);
        #2;
        n_rst = 1'b0;
        byte_q.delete();
        lastf_q.delete();
        exp_q.delete();
        pend_valid = 1'b0;
        armed = 1'b0;
        @(negedge clk);
        check("abort_line", {6'b0, dplus_out, dminus_out}, 8'h02);
        check("abort_busy", {7'b0, tx_busy}, 8'd0);
        repeat (2) @(posedge clk);
        #2;
        n_rst = 1'b1;
        free_run = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        check("post_abort_line", {6'b0, dplus_out, dminus_out}, 8'h02);
        check("post_abort_busy", {7'b0, tx_busy}, 8'd0);

        // Clean packet after the abort.
        push_byte(8'h00, 1'b1);
        push_str("KJKJKJKK JKJKJKJK SSJ", 7, -1, -1);
        launch(1'b0);
        wait_idle("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
